// File: rtl/sha256_stream_core_if.sv
// Block stream and digest bus between the nonce feeder, the SHA-256 core and the
// difficulty comparator. The core takes the slave side.
interface sha256_stream_core_if #(
   parameter int CNT_W = 16
);
   logic [511:0]     blk_data;
   logic             blk_valid;
   logic             blk_last;
   logic             blk_ready;
   logic             dbl_mode;
   logic             abort;
   logic             busy;
   logic [255:0]     digest;
   logic             digest_valid;
   logic [CNT_W-1:0] blk_count;

   modport master (
      output blk_data, blk_valid, blk_last, dbl_mode, abort,
      input  blk_ready, busy, digest, digest_valid, blk_count
   );

   modport slave (
      input  blk_data, blk_valid, blk_last, dbl_mode, abort,
      output blk_ready, busy, digest, digest_valid, blk_count
   );
endinterface

// File: rtl/sha256_stream_core.sv
// Streaming SHA-256 engine: one round per cycle over a rolling 16-word schedule,
// multi-block messages, optional double hash of the digest, and an abort path.
module sha256_stream_core #(
   parameter bit DOUBLE_EN = 1'b1,
   parameter int CNT_W     = 16
) (
   input logic                 clk,
   input logic                 n_rst,
   sha256_stream_core_if.slave bus
);

   typedef enum logic [2:0] {S_IDLE, S_ROUND, S_ACCUM, S_WAIT_BLK, S_DONE} state_t;

   localparam logic [31:0] IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [31:0] K_ROM [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   state_t           state_q;
   logic [5:0]       rnd_q;
   logic [31:0]      h_q [8];
   logic [31:0]      v_q [8];
   logic [31:0]      w_q [16];
   logic             last_q;
   logic             dbl_q;
   logic             pass2_q;
   logic             ready_q;
   logic             busy_q;
   logic             dvalid_q;
   logic [CNT_W-1:0] cnt_q;
   logic [255:0]     digest_q;

   logic [31:0]  t1, t2, w_d;
   logic [31:0]  v_d   [8];
   logic [31:0]  h_sum [8];
   logic [255:0] h_flat;
   logic         take_pass2;

   // NOTE: combinational logic uses blocking '=' so t1/t2 are read back within the same pass,
   // and every output is assigned unconditionally so no latch can be inferred.
   always_comb begin
      t1 = v_q[7] + (rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25))
         + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + K_ROM[rnd_q] + w_q[0];
      t2 = (rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22))
         + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
      v_d[0] = t1 + t2;
      v_d[1] = v_q[0];
      v_d[2] = v_q[1];
      v_d[3] = v_q[2];
      v_d[4] = v_q[3] + t1;
      v_d[5] = v_q[4];
      v_d[6] = v_q[5];
      v_d[7] = v_q[6];
      // w_q[k] holds W[r+k]; this is W[r+16], entering the window as W[r] leaves it
      w_d = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
          + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
      for (int i = 0; i < 8; i++) h_sum[i] = h_q[i] + v_q[i];
   end

   assign h_flat     = {h_sum[0], h_sum[1], h_sum[2], h_sum[3], h_sum[4], h_sum[5], h_sum[6], h_sum[7]};
   assign take_pass2 = DOUBLE_EN && last_q && dbl_q && !pass2_q;

   // NOTE: the schedule window has no reset; it is always loaded before a round reads it.
   always_ff @(posedge clk) begin
      if (bus.blk_valid && ready_q) begin
         for (int i = 0; i < 16; i++) w_q[i] <= bus.blk_data[511-32*i -: 32];
      end else if (state_q == S_ACCUM && take_pass2) begin
         // 256-bit first digest, padded as a one-block message of length 0x100
         for (int i = 0; i < 8; i++) w_q[i] <= h_sum[i];
         w_q[8] <= 32'h8000_0000;
         for (int i = 9; i < 15; i++) w_q[i] <= '0;
         w_q[15] <= 32'h0000_0100;
      end else if (state_q == S_ROUND) begin
         for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
         w_q[15] <= w_d;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= S_IDLE;
         rnd_q    <= '0;
         last_q   <= 1'b0;
         dbl_q    <= 1'b0;
         pass2_q  <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         dvalid_q <= 1'b0;
         cnt_q    <= '0;
         digest_q <= '0;
         for (int i = 0; i < 8; i++) begin
            h_q[i] <= IV[i];
            v_q[i] <= '0;
         end
      end else if (bus.abort) begin
         // abort outranks any handshake in the same cycle; the last digest stays visible
         state_q  <= S_IDLE;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         dvalid_q <= 1'b0;
         cnt_q    <= '0;
         for (int i = 0; i < 8; i++) h_q[i] <= IV[i];
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.blk_valid) begin
                  state_q  <= S_ROUND;
                  rnd_q    <= '0;
                  last_q   <= bus.blk_last;
                  dbl_q    <= DOUBLE_EN && bus.dbl_mode;
                  pass2_q  <= 1'b0;
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  dvalid_q <= 1'b0;
                  cnt_q    <= CNT_W'(1);
                  for (int i = 0; i < 8; i++) begin
                     h_q[i] <= IV[i];
                     v_q[i] <= IV[i];
                  end
               end
            end
            S_WAIT_BLK: begin
               if (bus.blk_valid) begin
                  state_q <= S_ROUND;
                  rnd_q   <= '0;
                  last_q  <= bus.blk_last;
                  ready_q <= 1'b0;
                  if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
                  for (int i = 0; i < 8; i++) v_q[i] <= h_q[i];
               end
            end
            S_ROUND: begin
               for (int i = 0; i < 8; i++) v_q[i] <= v_d[i];
               rnd_q <= rnd_q + 6'd1;
               if (rnd_q == 6'd63) state_q <= S_ACCUM;
            end
            S_ACCUM: begin
               for (int i = 0; i < 8; i++) h_q[i] <= h_sum[i];
               if (!last_q) begin
                  state_q <= S_WAIT_BLK;
                  ready_q <= 1'b1;
               end else if (take_pass2) begin
                  state_q <= S_ROUND;
                  rnd_q   <= '0;
                  pass2_q <= 1'b1;
                  for (int i = 0; i < 8; i++) begin
                     h_q[i] <= IV[i];
                     v_q[i] <= IV[i];
                  end
               end else begin
                  state_q  <= S_DONE;
                  digest_q <= h_flat;
                  dvalid_q <= 1'b1;
                  ready_q  <= 1'b1;
                  busy_q   <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.blk_ready    = ready_q;
   assign bus.busy         = busy_q;
   assign bus.digest       = digest_q;
   assign bus.digest_valid = dvalid_q;
   assign bus.blk_count    = cnt_q;

endmodule
